inv_subbytes_seq: RTL and testbench



---
 rtl/inv_subbytes_seq_if.sv | 22 ++
 rtl/inv_subbytes_seq.sv | 51 +++++
 tb/tb_inv_subbytes_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/inv_subbytes_seq_if.sv
// inv_subbytes_seq_if: upstream/downstream valid-ready handshake plus the S-box bank bus
interface inv_subbytes_seq_if #(
  parameter int LANES = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [127:0]       in_data;
  logic [8*LANES-1:0] sb_in;
  logic [8*LANES-1:0] sb_out;
  logic               out_valid;
  logic               out_ready;
  logic [127:0]       out_data;
  logic               busy;
  modport slave (
    input  in_valid, in_data, sb_out, out_ready,
    output in_ready, sb_in, out_valid, out_data, busy
  );
  modport master (
    output in_valid, in_data, sb_out, out_ready,
    input  in_ready, sb_in, out_valid, out_data, busy
  );
endinterface

// File: rtl/inv_subbytes_seq.sv
// inv_subbytes_seq: multi-cycle InvSubBytes over a LANES-wide external inverse S-box bank
module inv_subbytes_seq #(
  parameter int LANES = 4
) (
  input logic               clk,
  input logic               rst_n,
  inv_subbytes_seq_if.slave bus
);
  localparam int BEATS = 16 / LANES;
  localparam int W = 8 * LANES;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [127:0]  din, res;
  logic [6:0]    base;
  logic          last, accept;
  // highest-order slice first; base is the top bit of the current beat's slice
  always_comb begin
    base = 7'(127 - W * int'(cnt));
    last = cnt == CW'(BEATS - 1);
    bus.in_ready = state == IDLE || (state == DONE && bus.out_ready);
    accept = bus.in_valid && bus.in_ready;
    state_nx = accept ? RUN :
               (state == RUN && last) ? DONE :
               (state == DONE && bus.out_ready) ? IDLE : state;
    bus.sb_in = state == RUN ? din[base -: W] : '0;
    bus.out_valid = state == DONE;
    bus.busy = state != IDLE;
    bus.out_data = res;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      din <= '0;
      res <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        din <= bus.in_data;
        cnt <= '0;
      end else if (state == RUN) begin
        res[base -: W] <= bus.sb_out;
        cnt <= last ? '0 : cnt + CW'(1);
      end
    end
endmodule

// File: tb/tb_inv_subbytes_seq.sv
// tb_inv_subbytes_seq: directed vectors, stall/reset corner cases, LANES sweep and a random stream vs. a reference model
module tb_inv_subbytes_seq;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  int errs = 0;
  int checks = 0;
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // x^254 is the GF(2^8) inverse (and maps 0 to 0)
  function automatic logic [7:0] ginv(logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, x);
    end
    return r;
  endfunction
  function automatic logic [7:0] inv_sbox(logic [7:0] x);
    return ginv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction
  function automatic logic [127:0] sub_all(logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sbox(x[8*i +: 8]);
    return r;
  endfunction
  inv_subbytes_seq_if #(.LANES(4)) bus();
  inv_subbytes_seq #(.LANES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.sb_out = 32'(sub_all(128'(bus.sb_in)));
  logic         sw_valid = 0;
  logic [127:0] sw_data = '0;
  logic [3:0]   sw_ov;
  logic [127:0] sw_od [4];
  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int LN = (g < 2) ? (1 << g) : (1 << (g + 1));
    inv_subbytes_seq_if #(.LANES(LN)) sif();
    inv_subbytes_seq #(.LANES(LN)) u (.clk(clk), .rst_n(rst_n), .bus(sif));
    assign sif.in_valid = sw_valid;
    assign sif.in_data = sw_data;
    assign sif.out_ready = 1'b0;
    assign sif.sb_out = (8*LN)'(sub_all(128'(sif.sb_in)));
    assign sw_ov[g] = sif.out_valid;
    assign sw_od[g] = sif.out_data;
  end
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // called at a negedge in IDLE; returns at a negedge back in IDLE
  task automatic run_block(input logic [127:0] d, input logic [127:0] e);
    bus.in_valid = 1;
    bus.in_data = d;
    bus.out_ready = 0;
    @(negedge clk);
    bus.in_valid = 0;
    bus.in_data = ~d;
    for (int b = 0; b < 4; b++) begin
      check("run sb_in", bus.sb_in, 32'(d >> (96 - 32 * b)));
      check("run out_valid low", bus.out_valid, 0);
      @(negedge clk);
    end
    check("done out_valid", bus.out_valid, 1);
    check("done out_data", bus.out_data, e);
    check("done in_ready low", bus.in_ready, 0);
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
    check("after pop out_valid", bus.out_valid, 0);
    check("after pop busy", bus.busy, 0);
  endtask
  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [3];
  logic [127:0] q [$];
  int lat [4];
  int exp_lat [4];
  int acc, outs, cyc;
  initial begin
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb};
    vecs[1] = '{{16{8'h63}}, 128'h0};
    vecs[2] = '{{16{8'hff}}, {16{8'h7d}}};
    exp_lat = '{16, 8, 2, 1};
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.out_ready = 0;
    repeat (2) @(negedge clk);
    check("reset out_valid", bus.out_valid, 0);
    check("reset busy", bus.busy, 0);
    check("reset sb_in", bus.sb_in, 0);
    check("reset out_data", bus.out_data, 0);
    check("reset in_ready", bus.in_ready, 1);
    rst_n = 1;
    for (int v = 0; v < 3; v++) run_block(vecs[v].din, vecs[v].exp);
    // downstream stall in DONE, then back-to-back accept on the releasing edge
    bus.in_valid = 1;
    bus.in_data = vecs[0].din;
    @(negedge clk);
    bus.in_valid = 0;
    repeat (4) @(negedge clk);
    bus.in_valid = 1;
    bus.in_data = vecs[2].din;
    for (int i = 0; i < 10; i++) begin
      check("stall out_valid", bus.out_valid, 1);
      check("stall out_data", bus.out_data, vecs[0].exp);
      check("stall in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.out_ready = 1;
    #1 check("release in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.out_ready = 0;
    bus.in_valid = 0;
    check("b2b out_valid low", bus.out_valid, 0);
    check("b2b busy", bus.busy, 1);
    check("b2b sb_in beat0", bus.sb_in, 32'hffffffff);
    repeat (3) @(negedge clk);
    check("b2b not early", bus.out_valid, 0);
    @(negedge clk);
    check("b2b out_valid", bus.out_valid, 1);
    check("b2b out_data", bus.out_data, vecs[2].exp);
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
    // asynchronous reset during beat 2
    bus.in_valid = 1;
    bus.in_data = vecs[0].din;
    @(negedge clk);
    bus.in_valid = 0;
    repeat (2) @(negedge clk);
    check("abort sb_in beat2", bus.sb_in, 32'h08090a0b);
    rst_n = 0;
    #1;
    check("abort out_valid", bus.out_valid, 0);
    check("abort busy", bus.busy, 0);
    check("abort sb_in", bus.sb_in, 0);
    check("abort out_data", bus.out_data, 0);
    check("abort in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    run_block(vecs[2].din, vecs[2].exp);
    // LANES sweep: latency and result per width
    sw_data = vecs[0].din;
    sw_valid = 1;
    @(negedge clk);
    sw_valid = 0;
    lat = '{0, 0, 0, 0};
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (sw_ov[i] && lat[i] == 0) lat[i] = k;
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sweep latency %0d", i), lat[i], exp_lat[i]);
      check($sformatf("sweep out_data %0d", i), sw_od[i], vecs[0].exp);
    end
    // random stream with downstream stalls against the reference model
    acc = 0;
    outs = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 40000) begin
      bus.in_valid = $urandom_range(0, 3) != 0;
      bus.in_data = {$urandom, $urandom, $urandom, $urandom};
      bus.out_ready = $urandom_range(0, 2) != 0;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL stream extra output: got %h expected none", bus.out_data);
        end else check("stream data", bus.out_data, q.pop_front());
        outs++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(sub_all(bus.in_data));
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    cyc = 0;
    while (q.size() > 0 && cyc < 100) begin
      #1;
      if (bus.out_valid) begin
        check("stream drain data", bus.out_data, q.pop_front());
        outs++;
      end
      @(negedge clk);
      cyc++;
    end
    repeat (6) @(negedge clk);
    check("stream tail idle", bus.out_valid, 0);
    check("stream accepted", acc, 1000);
    check("stream delivered", outs, 1000);
    check("stream queue empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
